// File: rtl/multiply_folded.sv
// rtl/multiply_folded.sv - folded, handshaked element-wise array multiplier with accumulate mode
//
// Computes A*B over NUM_ELEMENTS words, consuming ROWS_PER_CYCLE rows of A per
// cycle into a column accumulator, then resolves one level of carries into
// 2*NUM_ELEMENTS output words of B_BIT_LEN bits (column split at WORD_LEN).
//
// Ports:
//   clk           clock
//   rst_n         synchronous active-low reset
//   in_valid      operands presented
//   in_ready      idle, will accept operands
//   in_accumulate sampled on accept; 1 keeps the accumulator (A*B + previous raw result)
//   A, B          operand words, NUM_ELEMENTS each
//   out_valid     result available
//   out_ready     consumer takes result
//   out           result words, 2*NUM_ELEMENTS
module multiply_folded #(
   parameter int NUM_ELEMENTS   = 33,
   parameter int A_BIT_LEN      = 17,
   parameter int B_BIT_LEN      = 17,
   parameter int WORD_LEN       = 16,
   parameter int ROWS_PER_CYCLE = 1,
   parameter int ACC_GUARD      = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_accumulate,
   input  logic [A_BIT_LEN-1:0] A [NUM_ELEMENTS],
   input  logic [B_BIT_LEN-1:0] B [NUM_ELEMENTS],
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [B_BIT_LEN-1:0] out [2*NUM_ELEMENTS]
);

   localparam int NUM_PASSES      = (NUM_ELEMENTS + ROWS_PER_CYCLE - 1) / ROWS_PER_CYCLE;
   localparam int MUL_OUT_BIT_LEN = A_BIT_LEN + B_BIT_LEN;
   localparam int COL_BIT_LEN     = MUL_OUT_BIT_LEN - WORD_LEN;
   localparam int COL_MAX         = (WORD_LEN > COL_BIT_LEN) ? WORD_LEN : COL_BIT_LEN;
   localparam int NUM_COLS        = 2 * NUM_ELEMENTS;
   localparam int ACC_BIT_LEN     = COL_MAX + $clog2(NUM_COLS) + ACC_GUARD;
   localparam int CARRY_BIT_LEN   = ACC_BIT_LEN - WORD_LEN;
   localparam int CTR_W           = $clog2(NUM_PASSES * ROWS_PER_CYCLE + 1);
   localparam int ROW_W           = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
   localparam int COL_W           = $clog2(NUM_COLS);

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      NORM,
      DONE
   } state_t;

   state_t                   state;
   logic [CTR_W-1:0]         ctr;
   logic [A_BIT_LEN-1:0]     a_reg [NUM_ELEMENTS];
   logic [B_BIT_LEN-1:0]     b_reg [NUM_ELEMENTS];
   logic [ACC_BIT_LEN-1:0]   acc [NUM_COLS];
   logic [ACC_BIT_LEN-1:0]   acc_next [NUM_COLS];
   logic [CARRY_BIT_LEN-1:0] carry_in [NUM_COLS];
   logic [B_BIT_LEN-1:0]     norm_word [NUM_COLS];

   // One pass of the fold: rows [ctr, ctr+ROWS_PER_CYCLE) of the partial-product
   // array are added into the columns. Rows past the end of A add nothing, which
   // handles the final partial pass.
   always_comb begin
      int                         row;
      logic [COL_W-1:0]           lo_col;
      logic [COL_W-1:0]           hi_col;
      logic [MUL_OUT_BIT_LEN-1:0] prod;
      row    = 0;
      lo_col = '0;
      hi_col = '0;
      prod   = '0;
      for (int k = 0; k < NUM_COLS; k++) begin
         acc_next[k] = acc[k];
      end
      for (int p = 0; p < ROWS_PER_CYCLE; p++) begin
         row = int'(ctr) + p;
         if (row < NUM_ELEMENTS) begin
            for (int j = 0; j < NUM_ELEMENTS; j++) begin
               prod   = MUL_OUT_BIT_LEN'(a_reg[row[ROW_W-1:0]]) * MUL_OUT_BIT_LEN'(b_reg[j]);
               lo_col = COL_W'(row + j);
               hi_col = lo_col + COL_W'(1);
               acc_next[lo_col] = acc_next[lo_col] + ACC_BIT_LEN'(prod[WORD_LEN-1:0]);
               acc_next[hi_col] = acc_next[hi_col] + ACC_BIT_LEN'(prod[MUL_OUT_BIT_LEN-1:WORD_LEN]);
            end
         end
      end
   end

   // Single carry-resolve step: each column keeps its low WORD_LEN bits and
   // receives the overflow of the column below. The top column's overflow is
   // dropped; sums wrap to B_BIT_LEN bits.
   always_comb begin
      carry_in[0] = '0;
      for (int k = 1; k < NUM_COLS; k++) begin
         carry_in[k] = acc[k-1][ACC_BIT_LEN-1:WORD_LEN];
      end
      for (int k = 0; k < NUM_COLS; k++) begin
         norm_word[k] = B_BIT_LEN'(acc[k][WORD_LEN-1:0]) + B_BIT_LEN'(carry_in[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         ctr       <= '0;
         for (int i = 0; i < NUM_ELEMENTS; i++) begin
            a_reg[i] <= '0;
            b_reg[i] <= '0;
         end
         for (int k = 0; k < NUM_COLS; k++) begin
            acc[k] <= '0;
            out[k] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg    <= A;
                  b_reg    <= B;
                  ctr      <= '0;
                  in_ready <= 1'b0;
                  state    <= MUL;
                  if (!in_accumulate) begin
                     for (int k = 0; k < NUM_COLS; k++) begin
                        acc[k] <= '0;
                     end
                  end
               end
            end
            MUL: begin
               acc <= acc_next;
               ctr <= ctr + CTR_W'(ROWS_PER_CYCLE);
               if (int'(ctr) + ROWS_PER_CYCLE >= NUM_ELEMENTS) begin
                  state <= NORM;
               end
            end
            NORM: begin
               out       <= norm_word;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               // Accumulator is left untouched so a following accumulate op can build on it.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multiply_folded.sv
// tb/tb_multiply_folded.sv - randomized and directed bench for multiply_folded (N=4, R=1 and R=3)
module tb_multiply_folded;

   localparam int N    = 4;
   localparam int NC   = 2 * N;
   localparam int ACCW = 23;  // max(16, 18) + clog2(8) + 2

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid;
   logic        in_accumulate;
   logic        out_ready;
   logic [16:0] a_in [N];
   logic [16:0] b_in [N];

   logic        in_ready1, out_valid1, in_ready3, out_valid3;
   logic [16:0] out1 [NC];
   logic [16:0] out3 [NC];

   longint      m_acc [NC];
   logic [16:0] exp_out [NC];

   int          total = 0;
   int          bad   = 0;

   multiply_folded #(.NUM_ELEMENTS(N), .ROWS_PER_CYCLE(1)) u_r1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .in_accumulate(in_accumulate), .A(a_in), .B(b_in),
      .out_valid(out_valid1), .out_ready(out_ready), .out(out1)
   );

   multiply_folded #(.NUM_ELEMENTS(N), .ROWS_PER_CYCLE(3)) u_r3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
      .in_accumulate(in_accumulate), .A(a_in), .B(b_in),
      .out_valid(out_valid3), .out_ready(out_ready), .out(out3)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: raw column sums of the whole product (mod 2^ACCW), then one carry step.
   task automatic model_apply(input bit accum);
      longint p;
      longint mask;
      longint s;
      mask = (64'd1 << ACCW) - 1;
      if (!accum) begin
         for (int k = 0; k < NC; k++) m_acc[k] = 0;
      end
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            p = longint'(a_in[i]) * longint'(b_in[j]);
            m_acc[i+j]   = (m_acc[i+j] + (p & 64'hFFFF)) & mask;
            m_acc[i+j+1] = (m_acc[i+j+1] + (p >> 16)) & mask;
         end
      end
      for (int k = 0; k < NC; k++) begin
         s = m_acc[k] & 64'hFFFF;
         if (k > 0) s = s + (m_acc[k-1] >> 16);
         exp_out[k] = 17'(s & 64'h1FFFF);
      end
   endtask

   task automatic set_ops(input logic [16:0] a0, input logic [16:0] b0, input bit rnd);
      for (int i = 0; i < N; i++) begin
         a_in[i] = rnd ? 17'($urandom_range(0, 17'h1FFFF)) : '0;
         b_in[i] = rnd ? 17'($urandom_range(0, 17'h1FFFF)) : '0;
      end
      if (!rnd) begin
         a_in[0] = a0;
         b_in[0] = b0;
      end
   endtask

   task automatic start_op(input bit accum);
      check("start_in_ready_r1", 64'(in_ready1), 64'd1);
      check("start_in_ready_r3", 64'(in_ready3), 64'd1);
      in_valid      = 1'b1;
      in_accumulate = accum;
      model_apply(accum);
      @(negedge clk);
      in_valid      = 1'b0;
      in_accumulate = 1'b0;
   endtask

   task automatic wait_done();
      int lat1;
      int lat3;
      lat1 = -1;
      lat3 = -1;
      for (int e = 1; e <= 40; e++) begin
         @(negedge clk);
         if (out_valid1 && lat1 < 0) lat1 = e;
         if (out_valid3 && lat3 < 0) lat3 = e;
         if (lat1 >= 0 && lat3 >= 0) break;
      end
      check("latency_r1", 64'(lat1), 64'd5);
      check("latency_r3", 64'(lat3), 64'd3);
      for (int k = 0; k < NC; k++) begin
         check($sformatf("out_r1[%0d]", k), 64'(out1[k]), 64'(exp_out[k]));
         check($sformatf("out_r3[%0d]", k), 64'(out3[k]), 64'(exp_out[k]));
      end
   endtask

   task automatic release_op();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("rel_out_valid_r1", 64'(out_valid1), 64'd0);
      check("rel_out_valid_r3", 64'(out_valid3), 64'd0);
      check("rel_in_ready_r1", 64'(in_ready1), 64'd1);
      check("rel_in_ready_r3", 64'(in_ready3), 64'd1);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_in_ready_r1"}, 64'(in_ready1), 64'd1);
      check({tag, "_in_ready_r3"}, 64'(in_ready3), 64'd1);
      check({tag, "_out_valid_r1"}, 64'(out_valid1), 64'd0);
      check({tag, "_out_valid_r3"}, 64'(out_valid3), 64'd0);
      for (int k = 0; k < NC; k++) begin
         check($sformatf("%s_out_r1[%0d]", tag, k), 64'(out1[k]), 64'd0);
         check($sformatf("%s_out_r3[%0d]", tag, k), 64'(out3[k]), 64'd0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [16:0] t1 [NC];
      logic [16:0] snap [NC];

      rst_n         = 1'b0;
      in_valid      = 1'b0;
      in_accumulate = 1'b0;
      out_ready     = 1'b0;
      set_ops('0, '0, 1'b0);
      for (int k = 0; k < NC; k++) m_acc[k] = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check_reset_state("reset");

      // Identity row: A={1,0,0,0} passes B straight through.
      set_ops(17'd1, 17'd0, 1'b0);
      b_in[0] = 17'd5; b_in[1] = 17'd6; b_in[2] = 17'd7; b_in[3] = 17'd8;
      t1 = '{17'd5, 17'd6, 17'd7, 17'd8, 17'd0, 17'd0, 17'd0, 17'd0};
      start_op(1'b0);
      wait_done();
      for (int k = 0; k < NC; k++) begin
         check($sformatf("ident_r1[%0d]", k), 64'(out1[k]), 64'(t1[k]));
      end
      release_op();

      // Full-scale single product: 0x1FFFF^2 = 0x3FFFC0001.
      set_ops(17'h1FFFF, 17'h1FFFF, 1'b0);
      start_op(1'b0);
      wait_done();
      check("max_out0", 64'(out1[0]), 64'h0001);
      check("max_out1", 64'(out1[1]), 64'hFFFC);
      check("max_out2", 64'(out1[2]), 64'h0003);
      check("max_out3", 64'(out1[3]), 64'h0000);
      release_op();

      // Accumulate chain: 1, then 1+1, then cleared back to 1.
      set_ops(17'd1, 17'd1, 1'b0);
      start_op(1'b0);
      wait_done();
      check("acc_op1", 64'(out1[0]), 64'd1);
      release_op();
      start_op(1'b1);
      wait_done();
      check("acc_op2_r1", 64'(out1[0]), 64'd2);
      check("acc_op2_r3", 64'(out3[0]), 64'd2);
      release_op();
      start_op(1'b0);
      wait_done();
      check("acc_op3", 64'(out1[0]), 64'd1);
      release_op();

      // Backpressure: result must hold while new operands are offered.
      set_ops('0, '0, 1'b1);
      start_op(1'b0);
      wait_done();
      snap = exp_out;
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1;
         set_ops('0, '0, 1'b1);
         @(negedge clk);
         check("bp_in_ready_r1", 64'(in_ready1), 64'd0);
         check("bp_in_ready_r3", 64'(in_ready3), 64'd0);
         check("bp_out_valid_r1", 64'(out_valid1), 64'd1);
         check("bp_out_valid_r3", 64'(out_valid3), 64'd1);
         for (int k = 0; k < NC; k++) begin
            check($sformatf("bp_out_r1[%0d]", k), 64'(out1[k]), 64'(snap[k]));
            check($sformatf("bp_out_r3[%0d]", k), 64'(out3[k]), 64'(snap[k]));
         end
      end
      in_valid = 1'b0;
      release_op();
      @(negedge clk);
      check("bp_idle_out_valid_r1", 64'(out_valid1), 64'd0);
      check("bp_idle_in_ready_r1", 64'(in_ready1), 64'd1);

      // Reset during the second MUL pass, then an accumulate op must see a clean accumulator.
      set_ops('0, '0, 1'b1);
      start_op(1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < NC; k++) m_acc[k] = 0;
      check_reset_state("midrst");
      set_ops(17'd2, 17'd3, 1'b0);
      start_op(1'b1);
      wait_done();
      check("midrst_op_r1", 64'(out1[0]), 64'd6);
      check("midrst_op_r3", 64'(out3[0]), 64'd6);
      release_op();

      // Random ops against the column model, with occasional accumulate chains.
      for (int n = 0; n < 1000; n++) begin
         set_ops('0, '0, 1'b1);
         start_op($urandom_range(0, 3) == 0);
         wait_done();
         release_op();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multiply_folded.md
Name: multiply_folded

Overview:
- Iterative, handshaked successor to the fully parallel element-wise array multiplier.
- Computes A*B over NUM_ELEMENTS words, processing ROWS_PER_CYCLE rows of A per cycle into a registered column accumulator, so DSP count scales with ROWS_PER_CYCLE*NUM_ELEMENTS instead of NUM_ELEMENTS^2.
- Output format is unchanged: 2*NUM_ELEMENTS partially carry-resolved words.
- Adds an accumulate mode (A*B + previous raw result) for multiply-accumulate use in the modular squaring datapath.

Parameters:
- NUM_ELEMENTS, 33, words per operand.
- A_BIT_LEN, 17, bits per A word.
- B_BIT_LEN, 17, bits per B word and per output word.
- WORD_LEN, 16, column split point.
- ROWS_PER_CYCLE, 1, A rows consumed per MUL cycle; 1..NUM_ELEMENTS.
- ACC_GUARD, 2, extra accumulator bits for accumulate mode.
- Derived: NUM_PASSES = ceil(NUM_ELEMENTS/ROWS_PER_CYCLE).
- Derived: MUL_OUT_BIT_LEN = A_BIT_LEN + B_BIT_LEN.
- Derived: COL_BIT_LEN = MUL_OUT_BIT_LEN - WORD_LEN.
- Derived: ACC_BIT_LEN = max(WORD_LEN, COL_BIT_LEN) + $clog2(2*NUM_ELEMENTS) + ACC_GUARD.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block idle, will accept.
- in_accumulate  input  1  sampled on accept; 1 = do not clear accumulator.
- A  input  [A_BIT_LEN-1:0] x NUM_ELEMENTS  multiplicand words.
- B  input  [B_BIT_LEN-1:0] x NUM_ELEMENTS  multiplier words.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- out  output  [B_BIT_LEN-1:0] x 2*NUM_ELEMENTS  result words.

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out all 0, accumulator all 0, row counter 0.
- IDLE: in_ready=1.
  - On in_valid: register A and B, capture in_accumulate, row counter=0.
  - Clear the accumulator unless in_accumulate=1.
  - Go to MUL.
- MUL: in_ready=0. Each cycle, for every row r in [ctr, ctr+ROWS_PER_CYCLE) with r < NUM_ELEMENTS, and every j:
  - add P[WORD_LEN-1:0] to acc[r+j];
  - add P[MUL_OUT_BIT_LEN-1:WORD_LEN] to acc[r+j+1], where P = A[r]*B[j].
  - Then ctr += ROWS_PER_CYCLE. After pass NUM_PASSES, go to NORM.
  - Final partial pass: rows >= NUM_ELEMENTS contribute zero.
- Row data source: operand registers only. A/B port changes after accept have no effect.
- NORM (1 cycle):
  - out[k] <= acc[k][WORD_LEN-1:0] + (k>0 ? acc[k-1][ACC_BIT_LEN-1:WORD_LEN] : 0), truncated mod 2^B_BIT_LEN.
  - acc[2N-1] upper bits are dropped.
  - out_valid <= 1; go to DONE.
- DONE: out_valid=1, out held stable, in_ready=0.
  - On out_ready: out_valid <= 0, go to IDLE.
  - Accumulator retained for a subsequent accumulate op.
- Latency: accept edge = edge 0. out_valid rises after edge NUM_PASSES+1. Throughput is one op per NUM_PASSES+3 cycles minimum.
- Width rules:
  - Column contributions are zero-extended to ACC_BIT_LEN.
  - Non-accumulate results are exact, no overflow.
  - Accumulate mode wraps mod 2^ACC_BIT_LEN per column beyond 2^ACC_GUARD accumulations. Caller's responsibility.
- in_valid while in_ready=0: ignored, not queued.
- rst_n low in any state: returns to reset values on that edge. rst_n has priority over the handshake. No partial result leaks into the next op.
- Internal multipliers may be pipelined only if NUM_PASSES/latency accounting is kept as stated; default is a combinational product per pass.

Test Plan:
- (N=4, R=1) A={1,0,0,0}, B={5,6,7,8}, acc=0 -> out[0..3]=5,6,7,8, out[4..7]=0; out_valid after edge 5.
- (N=4, R=1) A0=B0=0x1FFFF, others 0 -> product 0x3FFFC0001; out[0]=0x0001, out[1]=0xFFFC, out[2]=0x0003, rest 0.
- (N=4, R=3) random full-range A,B -> NUM_PASSES=2; out_valid after edge 3; out matches golden reference column model (including truncation) over 1000 random ops.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 and changing A -> out stable, in_ready=0, no new op accepted; out_ready=1 -> out_valid falls next edge, in_ready=1.
- Accumulate: op1 A0=B0=1, in_accumulate=0 -> out[0]=1. Op2 same operands, in_accumulate=1 -> out[0]=2. Op3 in_accumulate=0 -> out[0]=1.
- Reset mid-MUL: rst_n=0 for one cycle at pass 2 -> next cycle in_ready=1, out_valid=0, out=0. Following op A={2,0,0,0}, B={3,0,0,0} gives out[0]=6, rest 0.
